// File: rtl/ball_if.sv
// Ball engine bus: detector and controller inputs to the motion engine, plus the
// registered ball state it returns to the detectors and the renderer.
interface ball_if;
  logic       frame_tick;
  logic       launch;
  logic [9:0] paddle_x;
  logic       bounced;
  logic [1:0] direction;
  logic [9:0] b_x;
  logic [9:0] b_y;
  logic [5:0] b_radius;
  logic       moving;
  logic       lost;

  modport master (
    output frame_tick, launch, paddle_x, bounced, direction,
    input  b_x, b_y, b_radius, moving, lost
  );

  modport slave (
    input  frame_tick, launch, paddle_x, bounced, direction,
    output b_x, b_y, b_radius, moving, lost
  );
endinterface

// File: rtl/ball_motion.sv
// Ball position/velocity engine: holds the ball on the paddle, steps it once per
// frame, reflects it off the side and top walls and reports loss at the bottom.
//
// state  | meaning
// HELD   | ball rides on the paddle, waiting for launch on a frame tick
// MOVING | ball steps +/-SPEED per axis each frame tick
// LOST   | ball left the bottom edge, frozen until the next frame tick
module ball_motion #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int RADIUS   = 4,
  parameter int SPEED    = 2,
  parameter int PADDLE_Y = 440
) (
  input logic clk,
  input logic rst,
  ball_if.slave bus
);

  localparam logic [1:0] B_LEFT  = 2'd0;
  localparam logic [1:0] B_RIGHT = 2'd1;
  localparam logic [1:0] B_UP    = 2'd2;
  localparam logic [1:0] B_DOWN  = 2'd3;

  localparam logic signed [10:0] STEP   = 11'(SPEED);
  localparam logic signed [10:0] X_MIN  = 11'(RADIUS);
  localparam logic signed [10:0] X_MAX  = 11'(SCREEN_W - 1 - RADIUS);
  localparam logic signed [10:0] Y_MIN  = 11'(RADIUS);
  localparam logic signed [10:0] Y_LOST = 11'(SCREEN_H - RADIUS);
  localparam logic [9:0]         HOLD_X = 10'(SCREEN_W / 2);
  localparam logic [9:0]         HOLD_Y = 10'(PADDLE_Y - RADIUS - 8);

  typedef enum logic [1:0] {HELD, MOVING, LOST} state_t;

  state_t            state, state_n;
  logic [9:0]        b_x, b_y, b_x_n, b_y_n;
  logic              dx_neg, dy_neg, dx_neg_n, dy_neg_n;
  logic              moving, lost, lost_n;
  logic signed [10:0] nx, ny;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= HELD;
      b_x    <= HOLD_X;
      b_y    <= HOLD_Y;
      dx_neg <= 1'b0;
      dy_neg <= 1'b1;
      moving <= 1'b0;
      lost   <= 1'b0;
    end else begin
      state  <= state_n;
      b_x    <= b_x_n;
      b_y    <= b_y_n;
      dx_neg <= dx_neg_n;
      dy_neg <= dy_neg_n;
      moving <= (state_n == MOVING);
      lost   <= lost_n;
    end
  end

  always_comb begin
    state_n  = state;
    b_x_n    = b_x;
    b_y_n    = b_y;
    dx_neg_n = dx_neg;
    dy_neg_n = dy_neg;
    lost_n   = 1'b0;
    nx       = '0;
    ny       = '0;
    case (state)
      HELD: begin
        b_x_n = bus.paddle_x;
        if (bus.frame_tick && bus.launch) begin
          state_n  = MOVING;
          dx_neg_n = 1'b0;
          dy_neg_n = 1'b1;
        end
      end
      MOVING: begin
        // Bounces force a sign rather than toggle, so a detector that stays
        // asserted for several cycles cannot make the ball oscillate.
        if (bus.bounced) begin
          case (bus.direction)
            B_LEFT:  dx_neg_n = 1'b1;
            B_RIGHT: dx_neg_n = 1'b0;
            B_UP:    dy_neg_n = 1'b1;
            B_DOWN:  dy_neg_n = 1'b0;
            default: ;
          endcase
        end
        if (bus.frame_tick) begin
          nx = dx_neg_n ? $signed({1'b0, b_x}) - STEP : $signed({1'b0, b_x}) + STEP;
          ny = dy_neg_n ? $signed({1'b0, b_y}) - STEP : $signed({1'b0, b_y}) + STEP;
          b_x_n = nx[9:0];
          b_y_n = ny[9:0];
          if (nx < X_MIN) begin
            b_x_n    = X_MIN[9:0];
            dx_neg_n = 1'b0;
          end else if (nx > X_MAX) begin
            b_x_n    = X_MAX[9:0];
            dx_neg_n = 1'b1;
          end
          if (ny < Y_MIN) begin
            b_y_n    = Y_MIN[9:0];
            dy_neg_n = 1'b0;
          end else if (ny >= Y_LOST) begin
            b_y_n   = Y_LOST[9:0];
            state_n = LOST;
            lost_n  = 1'b1;
          end
        end
      end
      LOST: begin
        if (bus.frame_tick) begin
          state_n  = HELD;
          b_x_n    = bus.paddle_x;
          b_y_n    = HOLD_Y;
          dx_neg_n = 1'b0;
          dy_neg_n = 1'b1;
        end
      end
      default: state_n = HELD;
    endcase
  end

  assign bus.b_x      = b_x;
  assign bus.b_y      = b_y;
  assign bus.b_radius = 6'(RADIUS);
  assign bus.moving   = moving;
  assign bus.lost     = lost;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: stimulus pushes hand-computed ball states into
// a scoreboard queue, a negedge monitor pops and compares them on their due cycle.
module tb_ball_motion;

  localparam logic [1:0] B_LEFT  = 2'd0;
  localparam logic [1:0] B_RIGHT = 2'd1;
  localparam logic [1:0] B_UP    = 2'd2;
  localparam logic [1:0] B_DOWN  = 2'd3;

  typedef struct packed {
    int         cyc;
    logic [9:0] x;
    logic [9:0] y;
    logic       mv;
    logic       ls;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;
  exp_t  exp_q[$];
  string name_q[$];

  ball_if bus();

  ball_motion dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input int dly, input string nm, input int ex, input int ey,
                          input bit emv, input bit els);
    exp_t e;
    e.cyc = cyc + dly;
    e.x   = 10'(ex);
    e.y   = 10'(ey);
    e.mv  = emv;
    e.ls  = els;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic do_tick(input bit chk, input string nm, input int ex, input int ey,
                         input bit emv, input bit els);
    @(negedge clk);
    bus.frame_tick = 1'b1;
    if (chk) push_exp(1, nm, ex, ey, emv, els);
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t  e;
    string nm;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: check due at cycle %0d was reached at cycle %0d", nm, e.cyc, cyc);
      end else if ({bus.b_x, bus.b_y, bus.moving, bus.lost, bus.b_radius} !==
                   {e.x, e.y, e.mv, e.ls, 6'd4}) begin
        n_fail++;
        $display("FAIL %s: got x=%0d y=%0d moving=%0b lost=%0b radius=%0d, want x=%0d y=%0d moving=%0b lost=%0b radius=4",
                 nm, bus.b_x, bus.b_y, bus.moving, bus.lost, bus.b_radius, e.x, e.y, e.mv, e.ls);
      end
    end
  end

  initial begin
    bus.frame_tick = 1'b0;
    bus.launch     = 1'b0;
    bus.paddle_x   = 10'd100;
    bus.bounced    = 1'b0;
    bus.direction  = B_LEFT;

    // reset and held-ball tracking
    @(negedge clk);
    push_exp(1, "reset_state", 320, 428, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    push_exp(1, "held_track", 100, 428, 0, 0);
    idle(1);
    do_tick(1, "held_tick_no_launch", 100, 428, 0, 0);
    bus.launch = 1'b1;
    push_exp(3, "launch_without_tick", 100, 428, 0, 0);
    idle(3);

    // launch, first step, static between ticks
    do_tick(1, "launch_tick", 100, 428, 1, 0);
    bus.launch = 1'b0;
    do_tick(1, "first_step", 102, 426, 1, 0);
    push_exp(4, "static_between_ticks", 102, 426, 1, 0);
    idle(4);

    // climb to the top wall: tick k puts the ball at (100+2k, 428-2k)
    for (int k = 2; k <= 212; k++)
      do_tick(k == 212, "reach_top", 100 + 2 * k, 428 - 2 * k, 1, 0);
    do_tick(1, "top_clamp", 526, 4, 1, 0);
    do_tick(1, "top_reflect", 528, 6, 1, 0);
    for (int k = 215; k <= 267; k++)
      do_tick(k == 267, "reach_right", 528 + 2 * (k - 214), 6 + 2 * (k - 214), 1, 0);
    do_tick(1, "right_clamp", 635, 114, 1, 0);
    do_tick(1, "right_reflect", 633, 116, 1, 0);
    for (int k = 270; k <= 448; k++)
      do_tick(k == 448, "reach_bottom", 633 - 2 * (k - 269), 116 + 2 * (k - 269), 1, 0);
    do_tick(1, "lost_pulse", 273, 476, 0, 1);
    push_exp(1, "lost_pulse_end", 273, 476, 0, 0);
    bus.bounced   = 1'b1;
    bus.direction = B_RIGHT;
    @(negedge clk);
    bus.bounced  = 1'b0;
    bus.paddle_x = 10'd11;
    bus.launch   = 1'b1;
    push_exp(1, "lost_frozen", 273, 476, 0, 0);
    do_tick(1, "lost_to_held", 11, 428, 0, 0);
    push_exp(3, "launch_blocked_on_return", 11, 428, 0, 0);
    idle(3);
    do_tick(1, "relaunch", 11, 428, 1, 0);
    bus.launch = 1'b0;

    // left wall and bounce handling
    bus.bounced   = 1'b1;
    bus.direction = B_LEFT;
    @(negedge clk);
    bus.bounced = 1'b0;
    do_tick(1, "bounce_left", 9, 426, 1, 0);
    do_tick(0, "", 0, 0, 0, 0);
    do_tick(1, "near_left", 5, 422, 1, 0);
    do_tick(1, "left_clamp", 4, 420, 1, 0);
    do_tick(1, "left_reflect", 6, 418, 1, 0);
    bus.bounced   = 1'b1;
    bus.direction = B_DOWN;
    @(negedge clk);
    bus.bounced = 1'b0;
    do_tick(1, "bounce_down", 8, 420, 1, 0);
    bus.bounced   = 1'b1;
    bus.direction = B_UP;
    idle(3);
    bus.bounced = 1'b0;
    do_tick(1, "bounce_up_repeated", 10, 418, 1, 0);
    @(negedge clk);
    bus.frame_tick = 1'b1;
    bus.bounced    = 1'b1;
    bus.direction  = B_DOWN;
    push_exp(1, "bounce_same_tick", 12, 420, 1, 0);
    @(negedge clk);
    bus.frame_tick = 1'b0;
    bus.bounced    = 1'b0;
    for (int k = 1; k <= 27; k++)
      do_tick(k == 27, "reach_bottom_2", 12 + 2 * k, 420 + 2 * k, 1, 0);
    do_tick(1, "lost_pulse_2", 68, 476, 0, 1);

    // asynchronous reset while LOST
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.b_x, bus.b_y, bus.moving, bus.lost} !== {10'd320, 10'd428, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset_in_lost: got x=%0d y=%0d moving=%0b lost=%0b, want x=320 y=428 moving=0 lost=0",
               bus.b_x, bus.b_y, bus.moving, bus.lost);
    end
    @(negedge clk);
    rst = 1'b0;
    push_exp(1, "track_after_reset", 11, 428, 0, 0);
    idle(1);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d checks still pending, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
